// File: rtl/branch_unit_if.sv
// branch_unit_if: control inputs and PC/status outputs of the branch unit
interface branch_unit_if #(
  parameter int PC_W = 16,
  parameter int SP_W = 4
);
  logic            en;
  logic [2:0]      br_op;
  logic [2:0]      cond;
  logic [PC_W-1:0] target;
  logic [3:0]      FLAGS;
  logic [PC_W-1:0] pc;
  logic            taken;
  logic            stack_err;
  logic            halted;
  logic [SP_W-1:0] sp;
  modport master (output en, br_op, cond, target, FLAGS, input pc, taken, stack_err, halted, sp);
  modport slave (input en, br_op, cond, target, FLAGS, output pc, taken, stack_err, halted, sp);
endinterface

// File: rtl/branch_unit.sv
// branch_unit: next-PC selection, conditional branches and a return-address stack
module branch_unit #(
  parameter int              PC_W        = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = 16'h0000
) (
  input logic         clk,
  input logic         rst,
  branch_unit_if.slave bus
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] FULL = SP_W'(STACK_DEPTH);
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            taken_q, taken_d, err_q, err_d, halted_q, halted_d;
  logic            flag_sel, cond_ok, push, active;
  logic [SP_W-2:0] top_idx;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  assign pc_inc  = pc_q + PC_W'(1);
  assign top_idx = sp_q[SP_W-2:0] - (SP_W-1)'(1);
  assign active  = bus.en && !halted_q;
  assign push    = active && bus.br_op == 3'b011 && sp_q != FULL;
  // condition decode; anything but "always" needs valid flags
  always_comb begin
    flag_sel = bus.cond == 3'd1 ?  bus.FLAGS[1] :
               bus.cond == 3'd2 ? !bus.FLAGS[1] :
               bus.cond == 3'd3 ?  bus.FLAGS[2] :
               bus.cond == 3'd4 ? !bus.FLAGS[2] :
               bus.cond == 3'd5 ?  bus.FLAGS[3] :
               bus.cond == 3'd6 ? !bus.FLAGS[3] : 1'b0;
    cond_ok  = bus.cond == 3'd0 || (bus.FLAGS[0] && flag_sel);
  end
  // next-state selection per branch op; failed stack ops fall through as SEQ
  always_comb begin
    pc_d     = pc_inc;
    sp_d     = sp_q;
    taken_d  = 1'b0;
    err_d    = err_q;
    halted_d = halted_q;
    if (!active) begin
      pc_d = pc_q;
    end else begin
      case (bus.br_op)
        3'b001: begin
          pc_d    = bus.target;
          taken_d = 1'b1;
        end
        3'b010: begin
          pc_d    = cond_ok ? bus.target : pc_inc;
          taken_d = cond_ok;
        end
        3'b011: begin
          if (sp_q != FULL) begin
            pc_d    = bus.target;
            sp_d    = sp_q + SP_W'(1);
            taken_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        3'b100: begin
          if (sp_q != '0) begin
            pc_d    = stack_q[top_idx];
            sp_d    = sp_q - SP_W'(1);
            taken_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        3'b101: begin
          pc_d     = pc_q;
          halted_d = 1'b1;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end
  // architectural state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_VEC;
      sp_q     <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end
  // return-address storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[SP_W-2:0]] <= pc_inc;
  end
  assign bus.pc        = pc_q;
  assign bus.taken     = taken_q;
  assign bus.stack_err = err_q;
  assign bus.halted    = halted_q;
  assign bus.sp        = sp_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed-vector self-checking bench for branch_unit
module tb_branch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  branch_unit_if #(.PC_W(16), .SP_W(4)) bus ();
  branch_unit #(.PC_W(16), .STACK_DEPTH(8), .RESET_VEC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] tgt);
    bus.en = 1'b1;
    bus.br_op = op;
    bus.target = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.br_op = 3'b000; bus.cond = 3'b000; bus.target = '0; bus.FLAGS = '0;
    rst = 1'b0;
    tick();
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", bus.pc); end
    checks++; if (bus.sp !== 4'd0) begin errors++; $display("FAIL reset_sp: got %0d want 0", bus.sp); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", bus.taken); end
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.stack_err); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    rst = 1'b1;
  endtask

  task automatic test_seq();
    drive(3'b000, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.pc !== 16'(i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, 16'(i)); end
      checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL seq_taken%0d: got %b want 0", i, bus.taken); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL async_reset_pc: got %h want 0000", bus.pc); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_wrap_jmp();
    drive(3'b001, 16'hFFFF);
    tick();
    drive(3'b000, 16'h0000);
    tick();
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h want 0000", bus.pc); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL wrap_taken: got %b want 0", bus.taken); end
    drive(3'b001, 16'h1234);
    tick();
    checks++; if (bus.pc !== 16'h1234) begin errors++; $display("FAIL jmp_pc: got %h want 1234", bus.pc); end
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL jmp_taken: got %b want 1", bus.taken); end
    drive(3'b110, 16'h5555);
    tick();
    checks++; if (bus.pc !== 16'h1235) begin errors++; $display("FAIL op110_pc: got %h want 1235", bus.pc); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL jmp_taken_once: got %b want 0", bus.taken); end
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL op110_err: got %b want 0", bus.stack_err); end
  endtask

  task automatic test_jcc();
    logic [7:0]  vec [11] = '{8'b001_0001_0, 8'b001_0011_1, 8'b001_0010_0, 8'b000_0010_1,
                              8'b010_0001_1, 8'b011_0101_1, 8'b100_0101_0, 8'b101_1001_1,
                              8'b110_1001_0, 8'b111_1111_0, 8'b110_0000_0};
    logic [15:0] exp_pc;
    for (int i = 0; i < 11; i++) begin
      exp_pc = vec[i][0] ? 16'h0040 : bus.pc + 16'h0001;
      drive(3'b010, 16'h0040);
      bus.cond = vec[i][7:5];
      bus.FLAGS = vec[i][4:1];
      tick();
      checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL jcc_pc%0d: got %h want %h", i, bus.pc, exp_pc); end
      checks++; if (bus.taken !== vec[i][0]) begin errors++; $display("FAIL jcc_taken%0d: got %b want %b", i, bus.taken, vec[i][0]); end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  ops [4] = '{3'b011, 3'b011, 3'b100, 3'b100};
    logic [15:0] tgts [4] = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    logic [15:0] pcs [4] = '{16'h0100, 16'h0200, 16'h0101, 16'h0011};
    logic [3:0]  sps [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    drive(3'b001, 16'h0010);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], tgts[i]);
      tick();
      checks++; if (bus.pc !== pcs[i]) begin errors++; $display("FAIL callret_pc%0d: got %h want %h", i, bus.pc, pcs[i]); end
      checks++; if (bus.sp !== sps[i]) begin errors++; $display("FAIL callret_sp%0d: got %0d want %0d", i, bus.sp, sps[i]); end
      checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL callret_taken%0d: got %b want 1", i, bus.taken); end
    end
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL callret_err: got %b want 0", bus.stack_err); end
  endtask

  task automatic test_stack_limits();
    do_reset();
    drive(3'b100, 16'h0000);
    tick();
    checks++; if (bus.pc !== 16'h0001) begin errors++; $display("FAIL underflow_pc: got %h want 0001", bus.pc); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL underflow_taken: got %b want 0", bus.taken); end
    checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", bus.stack_err); end
    checks++; if (bus.sp !== 4'd0) begin errors++; $display("FAIL underflow_sp: got %0d want 0", bus.sp); end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(3'b011, 16'h1000 + 16'(i * 16));
      tick();
    end
    checks++; if (bus.sp !== 4'd8) begin errors++; $display("FAIL fill_sp: got %0d want 8", bus.sp); end
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b want 0", bus.stack_err); end
    drive(3'b011, 16'h2000);
    tick();
    checks++; if (bus.pc !== 16'h1071) begin errors++; $display("FAIL overflow_pc: got %h want 1071", bus.pc); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL overflow_taken: got %b want 0", bus.taken); end
    checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b want 1", bus.stack_err); end
    checks++; if (bus.sp !== 4'd8) begin errors++; $display("FAIL overflow_sp: got %0d want 8", bus.sp); end
    drive(3'b100, 16'h0000);
    tick();
    checks++; if (bus.pc !== 16'h1061) begin errors++; $display("FAIL pop_top_pc: got %h want 1061", bus.pc); end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (bus.pc !== 16'h0001) begin errors++; $display("FAIL pop_bottom_pc: got %h want 0001", bus.pc); end
    checks++; if (bus.sp !== 4'd0) begin errors++; $display("FAIL pop_bottom_sp: got %0d want 0", bus.sp); end
    checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.stack_err); end
  endtask

  task automatic test_enable();
    do_reset();
    drive(3'b011, 16'h0300);
    tick();
    drive(3'b100, 16'h0000);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== 16'h0300) begin errors++; $display("FAIL en_hold_pc%0d: got %h want 0300", i, bus.pc); end
      checks++; if (bus.sp !== 4'd1) begin errors++; $display("FAIL en_hold_sp%0d: got %0d want 1", i, bus.sp); end
      checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL en_hold_taken%0d: got %b want 0", i, bus.taken); end
    end
    bus.en = 1'b1;
    tick();
    checks++; if (bus.pc !== 16'h0001) begin errors++; $display("FAIL en_resume_pc: got %h want 0001", bus.pc); end
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL en_resume_taken: got %b want 1", bus.taken); end
  endtask

  task automatic test_back_to_back();
    drive(3'b001, 16'h2000);
    tick();
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL b2b_taken0: got %b want 1", bus.taken); end
    drive(3'b001, 16'h3000);
    tick();
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL b2b_taken1: got %b want 1", bus.taken); end
    checks++; if (bus.pc !== 16'h3000) begin errors++; $display("FAIL b2b_pc: got %h want 3000", bus.pc); end
  endtask

  task automatic test_halt();
    drive(3'b101, 16'h0000);
    tick();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
    checks++; if (bus.pc !== 16'h3000) begin errors++; $display("FAIL halt_pc: got %h want 3000", bus.pc); end
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL halt_taken: got %b want 0", bus.taken); end
    bus.cond = 3'b000;
    for (int i = 0; i < 10; i++) begin
      drive(3'(i), 16'hAAAA);
      tick();
      checks++; if (bus.pc !== 16'h3000) begin errors++; $display("FAIL halted_pc%0d: got %h want 3000", i, bus.pc); end
      checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL halted_taken%0d: got %b want 0", i, bus.taken); end
      checks++; if (bus.sp !== 4'd0) begin errors++; $display("FAIL halted_sp%0d: got %0d want 0", i, bus.sp); end
    end
    do_reset();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b want 0", bus.halted); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_wrap_jmp();
    test_jcc();
    test_call_ret();
    test_stack_limits();
    test_enable();
    test_back_to_back();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
